// File: rtl/fpu_pkg.sv
// Shared FPU constants and helpers: exponent widths, shift-direction encoding
// and the largest finite biased exponent.
package fpu_pkg;

    localparam int unsigned EXP_W_SP = 8;
    localparam int unsigned EXP_W_DP = 11;

    localparam logic LR_RIGHT = 1'b0;
    localparam logic LR_LEFT  = 1'b1;

    typedef enum logic {
        ShiftRight = 1'b0,
        ShiftLeft  = 1'b1
    } shift_dir_e;

    // All-ones is the Inf/NaN exponent, so the largest finite value is one below it.
    function automatic int unsigned exp_max(input int unsigned e_w);
        return (32'd1 << e_w) - 32'd2;
    endfunction

endpackage

// File: rtl/exp_adj_stage.sv
// Generic valid/ready register slice: accepts when empty or when downstream
// drains in the same cycle; payload registers load only on an upstream transfer.
module exp_adj_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q;
    logic         up_xfer;

    assign up_ready = ~valid_q | dn_ready;
    assign up_xfer  = up_valid & up_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        if (up_xfer) begin
            valid_d = 1'b1;
        end else if (dn_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (up_xfer) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/exp_adjust_pipe.sv
// Pipelined exponent adjust: biased exponent +/- shift count with overflow and
// underflow flags. Define EXP_ADJ_SAT_EN to saturate out_exp on ovf/unf.
module exp_adjust_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned E_W   = EXP_W_SP,
    parameter int unsigned SH_W  = 5,
    parameter int unsigned PIPE  = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_lr_bar,
    input  logic [SH_W-1:0]  in_shift,
    input  logic [E_W-1:0]   in_exp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [E_W-1:0]   out_exp,
    output logic             out_ovf,
    output logic             out_unf,
    output logic [TAG_W-1:0] out_tag
);

    // Sum carries one magnitude bit above the exponent plus a sign bit.
    localparam int unsigned S_W = E_W + 2;
    localparam int unsigned R_W = E_W + 2;
    localparam int unsigned PW  = TAG_W + E_W + 2;
    localparam logic [S_W-1:0] EXP_MAX_S = S_W'(exp_max(E_W));

    logic [S_W-1:0] shift_ext;
    logic [S_W-1:0] sum;
    logic [PW-1:0]  out_data;

    assign shift_ext = S_W'(in_shift);

    always_comb begin
        if (in_lr_bar == LR_LEFT) begin
            sum = {2'b00, in_exp} + ~shift_ext + S_W'(1);
        end else begin
            sum = {2'b00, in_exp} + shift_ext;
        end
    end

    // Returns {ovf, unf, exp} for a raw signed sum.
    function automatic logic [R_W-1:0] resolve(input logic [S_W-1:0] s);
        logic           ovf;
        logic           unf;
        logic [E_W-1:0] e;
        ovf = ~s[S_W-1] & (s > EXP_MAX_S);
        unf = s[S_W-1] | (s == '0);
        e   = s[E_W-1:0];
`ifdef EXP_ADJ_SAT_EN
        if (ovf) begin
            e = '1;
        end else if (unf) begin
            e = '0;
        end
`endif
        return {ovf, unf, e};
    endfunction

    if (PIPE == 1) begin : gen_pipe1
        exp_adj_stage #(
            .W(PW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (in_valid),
            .up_ready (in_ready),
            .up_data  ({in_tag, resolve(sum)}),
            .dn_valid (out_valid),
            .dn_ready (out_ready),
            .dn_data  (out_data)
        );
    end else begin : gen_pipe2
        logic          s1_valid;
        logic          s1_ready;
        logic [PW-1:0] s1_data;

        // Stage 1 holds {tag, raw sum}; stage 2 resolves flags and exponent.
        exp_adj_stage #(
            .W(PW)
        ) u_stage1 (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (in_valid),
            .up_ready (in_ready),
            .up_data  ({in_tag, sum}),
            .dn_valid (s1_valid),
            .dn_ready (s1_ready),
            .dn_data  (s1_data)
        );

        exp_adj_stage #(
            .W(PW)
        ) u_stage2 (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (s1_valid),
            .up_ready (s1_ready),
            .up_data  ({s1_data[PW-1 -: TAG_W], resolve(s1_data[S_W-1:0])}),
            .dn_valid (out_valid),
            .dn_ready (out_ready),
            .dn_data  (out_data)
        );
    end

    assign {out_tag, out_ovf, out_unf, out_exp} = out_data;

endmodule
